// File: rtl/ahb_gpio_bridge_pkg.sv
// Shared constants and types for the AHB-Lite to 4-group GPIO bridge.
package gpio_pkg;

  localparam int unsigned GROUP_NUM = 4;

  localparam logic [3:0] OFF_OUT = 4'h0;
  localparam logic [3:0] OFF_OEN = 4'h4;
  localparam logic [3:0] OFF_IN  = 4'h8;
  localparam logic [3:0] OFF_RSV = 4'hC;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {IDLE, RD_SEL, RD_WAIT, RD_DONE} state_t;

  typedef enum logic [1:0] {REG_OUT, REG_OEN, REG_IN, REG_RSV} reg_t;

  // Sub-word offsets (e.g. a byte at 0x1) select the register of their word.
  function automatic reg_t decode_off(input logic [3:0] off);
    case (off & 4'hC)
      OFF_OUT: return REG_OUT;
      OFF_OEN: return REG_OEN;
      OFF_IN:  return REG_IN;
      default: return REG_RSV;
    endcase
  endfunction

endpackage

// File: rtl/ahb_gpio_bridge_if.sv
// AHB-Lite slave-side signal bundle for the GPIO bridge.
interface ahb_gpio_bridge_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_gpio_bridge_byte_strobe.sv
// Byte-lane strobe from HSIZE and the low address bits; sizes above word act as word.
module ahb_byte_strobe
  import gpio_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr,
  output logic [3:0] strobe
);

  always_comb begin
    strobe = 4'b1111;
    case (size)
      HSIZE_BYTE: strobe = 4'b0001 << addr;
      HSIZE_HALF: strobe = 4'b0011 << {addr[1], 1'b0};
      default:    strobe = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahb_gpio_bridge.sv
// AHB-Lite slave holding per-group GPIO shadows and sequencing group_id toward the GPIO block.
module ahb_gpio_bridge
  import gpio_pkg::*;
#(
  parameter int unsigned GROUP_W = 4
) (
  input  logic                clk,
  input  logic                RST,
  ahb_gpio_bridge_if.slave    bus,
  output logic [3:0]          write_byte,
  output logic [GROUP_W-1:0]  group_id,
  output logic [31:0]         o_ena,
  output logic [31:0]         o_dat,
  input  logic [31:0]         i_dat
);

  state_t      state;
  logic        hready_q;
  logic        dp_valid;
  logic        dp_write;
  logic [1:0]  dp_g;
  reg_t        dp_reg;
  logic [2:0]  dp_size;
  logic [1:0]  dp_addr;
  logic [3:0]  strobe;
  logic [31:0] rdata;
  logic        accept;
  logic        commit;
  logic        unused_inputs;

  logic [31:0] shadow_dat [GROUP_NUM];
  logic [31:0] shadow_en  [GROUP_NUM];

  assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign commit = dp_valid & dp_write & bus.HREADY;
  assign unused_inputs = ^{bus.HADDR[31:6], bus.HTRANS[0]};

  ahb_byte_strobe u_strobe (
    .size   (dp_size),
    .addr   (dp_addr),
    .strobe (strobe)
  );

  // Data-phase context; held while the slave stretches a read.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_g     <= '0;
      dp_reg   <= REG_OUT;
      dp_size  <= '0;
      dp_addr  <= '0;
    end else if (bus.HREADY) begin
      dp_valid <= accept;
      if (accept) begin
        dp_write <= bus.HWRITE;
        dp_g     <= bus.HADDR[5:4];
        dp_reg   <= decode_off(bus.HADDR[3:0]);
        dp_size  <= bus.HSIZE;
        dp_addr  <= bus.HADDR[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < GROUP_NUM; i++) begin
        shadow_dat[i] <= '0;
        shadow_en[i]  <= '0;
      end
    end else if (commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (strobe[b]) begin
          if (dp_reg == REG_OUT) shadow_dat[dp_g][8*b +: 8] <= bus.HWDATA[8*b +: 8];
          if (dp_reg == REG_OEN) shadow_en[dp_g][8*b +: 8]  <= bus.HWDATA[8*b +: 8];
        end
      end
    end
  end

  // RD_SEL keeps group_id for one edge so a write committed as the read was
  // accepted still reaches its own group before the read group is selected.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      hready_q   <= 1'b1;
      group_id   <= '0;
      write_byte <= '0;
    end else begin
      write_byte <= '0;
      if (commit) begin
        group_id <= GROUP_W'(dp_g);
        if (dp_reg == REG_OUT || dp_reg == REG_OEN) write_byte <= strobe;
      end
      case (state)
        IDLE, RD_DONE: begin
          if (accept && !bus.HWRITE && decode_off(bus.HADDR[3:0]) == REG_IN) begin
            state    <= RD_SEL;
            hready_q <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RD_SEL: begin
          group_id <= GROUP_W'(dp_g);
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          state    <= RD_DONE;
          hready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (state == RD_DONE) begin
      rdata = i_dat;
    end else if (dp_valid && !dp_write) begin
      case (dp_reg)
        REG_OUT: rdata = shadow_dat[dp_g];
        REG_OEN: rdata = shadow_en[dp_g];
        default: rdata = '0;
      endcase
    end
  end

  assign o_dat         = shadow_dat[group_id[1:0]];
  assign o_ena         = shadow_en[group_id[1:0]];
  assign bus.HREADYOUT = hready_q;
  assign bus.HRDATA    = rdata;
  assign bus.HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_gpio_bridge.sv
// Self-checking bench for ahb_gpio_bridge with a GPIO pin model and a register-level reference.
module tb_ahb_gpio_bridge;
  import gpio_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  write_byte;
  logic [3:0]  group_id;
  logic [31:0] o_ena;
  logic [31:0] o_dat;
  logic [31:0] i_dat;

  int tests = 0;
  int fails = 0;

  ahb_gpio_bridge_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_gpio_bridge #(.GROUP_W(4)) dut (
    .clk        (clk),
    .RST        (rst),
    .bus        (bus),
    .write_byte (write_byte),
    .group_id   (group_id),
    .o_ena      (o_ena),
    .o_dat      (o_dat),
    .i_dat      (i_dat)
  );

  always #5 clk = ~clk;

  // GPIO block: per-group output registers loaded by byte lane, registered pin input.
  logic [31:0] g_out [4];
  logic [31:0] g_en  [4];
  logic [31:0] ext_en  [4];
  logic [31:0] ext_val [4];
  logic [31:0] ref_dat [4];
  logic [31:0] ref_en  [4];
  int          rd_waits;
  logic [3:0]  rd_gid_q [$];

  function automatic logic [31:0] pin_val(input logic [31:0] en, input logic [31:0] out,
                                          input logic [31:0] xen, input logic [31:0] xval);
    return (en & out) | (~en & xen & xval);
  endfunction

  function automatic logic [31:0] pin_drv(input logic [31:0] en, input logic [31:0] xen);
    return en | xen;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        g_out[i] <= '0;
        g_en[i]  <= '0;
      end
      i_dat <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (write_byte[b]) begin
          g_out[group_id[1:0]][8*b +: 8] <= o_dat[8*b +: 8];
          g_en[group_id[1:0]][8*b +: 8]  <= o_ena[8*b +: 8];
        end
      end
      i_dat <= pin_val(g_en[group_id[1:0]], g_out[group_id[1:0]],
                       ext_en[group_id[1:0]], ext_val[group_id[1:0]]);
    end
  end

  // Lanes covered by an access of 2**size bytes at its naturally aligned base.
  function automatic logic [3:0] ref_lanes(input logic [2:0] size, input logic [1:0] a);
    int unsigned n;
    int unsigned base;
    logic [3:0]  m;
    n    = (size >= 3'd2) ? 4 : (1 << size);
    base = (int'(a) / n) * n;
    m    = '0;
    for (int unsigned i = 0; i < 4; i++) m[i] = (i >= base) && (i < base + n);
    return m;
  endfunction

  task automatic ref_write(input logic [5:0] a, input logic [2:0] s, input logic [31:0] d,
                           output logic [3:0] wb);
    logic [3:0] l;
    wb = '0;
    if (a[3:2] < 2'd2) begin
      l  = ref_lanes(s, a[1:0]);
      wb = l;
      for (int b = 0; b < 4; b++) begin
        if (l[b]) begin
          if (a[3:2] == 2'd0) ref_dat[a[5:4]][8*b +: 8] = d[8*b +: 8];
          else                ref_en[a[5:4]][8*b +: 8]  = d[8*b +: 8];
        end
      end
    end
  endtask

  task automatic ahb_addr(input logic [31:0] a, input logic w, input logic [2:0] s);
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HADDR  = a;
    bus.HWRITE = w;
    bus.HSIZE  = s;
  endtask

  task automatic ahb_idle_addr();
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    ahb_addr(a, 1'b1, s);
    @(posedge clk); #1;
    ahb_idle_addr();
    bus.HWDATA = d;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] s, output logic [31:0] d);
    ahb_addr(a, 1'b0, s);
    @(posedge clk); #1;
    ahb_idle_addr();
    rd_waits = 0;
    rd_gid_q.delete();
    while (bus.HREADYOUT !== 1'b1 && rd_waits < 16) begin
      rd_gid_q.push_back(group_id);
      rd_waits++;
      @(posedge clk); #1;
    end
    d = bus.HRDATA;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ahb_idle_addr();
    bus.HADDR = '0; bus.HWRITE = 1'b0; bus.HSIZE = HSIZE_WORD; bus.HWDATA = '0;
    for (int i = 0; i < 4; i++) begin
      ext_en[i] = '0; ext_val[i] = '0; ref_dat[i] = '0; ref_en[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (o_ena !== 32'h0) begin fails++; $display("FAIL reset_o_ena got %h exp 0", o_ena); end
    tests++; if (o_dat !== 32'h0) begin fails++; $display("FAIL reset_o_dat got %h exp 0", o_dat); end
    tests++; if (group_id !== 4'h0) begin fails++; $display("FAIL reset_group_id got %h exp 0", group_id); end
    tests++; if (write_byte !== 4'h0) begin fails++; $display("FAIL reset_write_byte got %h exp 0", write_byte); end
    tests++; if (bus.HREADYOUT !== 1'b1) begin fails++; $display("FAIL reset_hreadyout got %b exp 1", bus.HREADYOUT); end
    tests++; if (bus.HRDATA !== 32'h0) begin fails++; $display("FAIL reset_hrdata got %h exp 0", bus.HRDATA); end
    for (int g = 0; g < 4; g++) begin
      tests++;
      if (pin_drv(g_en[g], ext_en[g]) !== 32'h0) begin
        fails++; $display("FAIL reset_pins_z g%0d driven mask %h exp 0", g, pin_drv(g_en[g], ext_en[g]));
      end
    end
  endtask

  task automatic test_word_write();
    logic [3:0] wb;
    do_write(32'h14, HSIZE_WORD, 32'h0000_00FF);
    ref_write(6'h14, HSIZE_WORD, 32'h0000_00FF, wb);
    tests++; if (group_id !== 4'd1) begin fails++; $display("FAIL ww_oen_gid got %h exp 1", group_id); end
    tests++; if (write_byte !== 4'hF) begin fails++; $display("FAIL ww_oen_wb got %h exp f", write_byte); end
    tests++; if (o_ena !== 32'hFF) begin fails++; $display("FAIL ww_oen_o_ena got %h exp ff", o_ena); end
    @(posedge clk); #1;
    tests++; if (write_byte !== 4'h0) begin fails++; $display("FAIL ww_wb_pulse got %h exp 0", write_byte); end
    do_write(32'h10, HSIZE_WORD, 32'h1234_56A5);
    ref_write(6'h10, HSIZE_WORD, 32'h1234_56A5, wb);
    tests++; if (group_id !== 4'd1) begin fails++; $display("FAIL ww_out_gid got %h exp 1", group_id); end
    tests++; if (write_byte !== 4'hF) begin fails++; $display("FAIL ww_out_wb got %h exp f", write_byte); end
    @(posedge clk); #1;
    tests++;
    if (pin_drv(g_en[1], ext_en[1]) !== 32'h0000_00FF) begin
      fails++; $display("FAIL ww_pin1_mask got %h exp 000000ff", pin_drv(g_en[1], ext_en[1]));
    end
    tests++;
    if (pin_val(g_en[1], g_out[1], ext_en[1], ext_val[1]) !== 32'h0000_00A5) begin
      fails++; $display("FAIL ww_pin1_val got %h exp 000000a5", pin_val(g_en[1], g_out[1], ext_en[1], ext_val[1]));
    end
  endtask

  task automatic test_byte_write();
    logic [3:0]  wb;
    logic [31:0] d;
    do_write(32'h20, HSIZE_WORD, 32'hFFFF_FFFF);
    ref_write(6'h20, HSIZE_WORD, 32'hFFFF_FFFF, wb);
    do_write(32'h21, HSIZE_BYTE, 32'h5A5A_5A5A);
    ref_write(6'h21, HSIZE_BYTE, 32'h5A5A_5A5A, wb);
    tests++; if (write_byte !== 4'b0010) begin fails++; $display("FAIL bw_wb got %b exp 0010", write_byte); end
    tests++; if (o_dat !== 32'hFFFF_5AFF) begin fails++; $display("FAIL bw_shadow got %h exp ffff5aff", o_dat); end
    do_read(32'h20, HSIZE_WORD, d);
    tests++; if (d !== ref_dat[2]) begin fails++; $display("FAIL bw_readback got %h exp %h", d, ref_dat[2]); end
    tests++; if (rd_waits != 0) begin fails++; $display("FAIL bw_read_waits got %0d exp 0", rd_waits); end
  endtask

  task automatic test_in_read();
    logic [31:0] d;
    ext_en[3]  = '1;
    ext_val[3] = 32'hCAFE_F00D;
    do_read(32'h38, HSIZE_WORD, d);
    tests++; if (rd_waits != 2) begin fails++; $display("FAIL in_waits got %0d exp 2", rd_waits); end
    tests++; if (d !== 32'hCAFE_F00D) begin fails++; $display("FAIL in_data got %h exp cafef00d", d); end
    tests++;
    if (rd_gid_q.size() != 2 || rd_gid_q[0] !== 4'd2 || rd_gid_q[1] !== 4'd3) begin
      fails++; $display("FAIL in_gid_seq got n=%0d exp held 2 then 3", rd_gid_q.size());
    end
    tests++; if (group_id !== 4'd3) begin fails++; $display("FAIL in_gid_after got %h exp 3", group_id); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  wb;
    logic [31:0] exp;
    do_write(32'h04, HSIZE_WORD, 32'h1);
    ref_write(6'h04, HSIZE_WORD, 32'h1, wb);
    ext_en[1]  = '1;
    ext_val[1] = $urandom;
    exp = pin_val(ref_en[1], ref_dat[1], ext_en[1], ext_val[1]);
    ahb_addr(32'h00, 1'b1, HSIZE_WORD);
    @(posedge clk); #1;
    ahb_addr(32'h18, 1'b0, HSIZE_WORD);
    bus.HWDATA = 32'h1;
    ref_write(6'h00, HSIZE_WORD, 32'h1, wb);
    @(posedge clk); #1;
    ahb_idle_addr();
    tests++; if (group_id !== 4'd0) begin fails++; $display("FAIL b2b_gid_first got %h exp 0", group_id); end
    tests++; if (write_byte !== 4'hF) begin fails++; $display("FAIL b2b_wb got %h exp f", write_byte); end
    tests++; if (bus.HREADYOUT !== 1'b0) begin fails++; $display("FAIL b2b_sel_ready got %b exp 0", bus.HREADYOUT); end
    @(posedge clk); #1;
    tests++; if (group_id !== 4'd1) begin fails++; $display("FAIL b2b_gid_second got %h exp 1", group_id); end
    @(posedge clk); #1;
    tests++; if (bus.HREADYOUT !== 1'b1) begin fails++; $display("FAIL b2b_done_ready got %b exp 1", bus.HREADYOUT); end
    tests++; if (bus.HRDATA !== exp) begin fails++; $display("FAIL b2b_rdata got %h exp %h", bus.HRDATA, exp); end
    @(posedge clk); #1;
    tests++;
    if (pin_val(g_en[0], g_out[0], 32'h0, 32'h0) !== 32'h1 || g_en[0][0] !== 1'b1) begin
      fails++; $display("FAIL b2b_pin0 got val %h en %h exp bit0 driven 1", g_out[0], g_en[0]);
    end
    // Consecutive writes to different groups, pipelined.
    ahb_addr(32'h20, 1'b1, HSIZE_WORD);
    @(posedge clk); #1;
    ahb_addr(32'h30, 1'b1, HSIZE_WORD);
    bus.HWDATA = 32'hA5A5_0002;
    ref_write(6'h20, HSIZE_WORD, 32'hA5A5_0002, wb);
    @(posedge clk); #1;
    ahb_idle_addr();
    tests++; if (group_id !== 4'd2 || o_dat !== ref_dat[2]) begin fails++; $display("FAIL b2b_ww_g2 got gid %h dat %h exp 2 %h", group_id, o_dat, ref_dat[2]); end
    bus.HWDATA = 32'h5A5A_0003;
    ref_write(6'h30, HSIZE_WORD, 32'h5A5A_0003, wb);
    @(posedge clk); #1;
    tests++; if (group_id !== 4'd3 || o_dat !== ref_dat[3]) begin fails++; $display("FAIL b2b_ww_g3 got gid %h dat %h exp 3 %h", group_id, o_dat, ref_dat[3]); end
    @(posedge clk); #1;
    tests++; if (g_out[2] !== ref_dat[2] || g_out[3] !== ref_dat[3]) begin fails++; $display("FAIL b2b_ww_gpio got %h %h exp %h %h", g_out[2], g_out[3], ref_dat[2], ref_dat[3]); end
  endtask

  task automatic test_reserved();
    logic [31:0] d;
    do_write(32'h2C, HSIZE_WORD, 32'hDEAD_BEEF);
    tests++; if (write_byte !== 4'h0 || group_id !== 4'd2) begin fails++; $display("FAIL rsv_write got wb %h gid %h exp 0 2", write_byte, group_id); end
    tests++; if (o_dat !== ref_dat[2] || o_ena !== ref_en[2]) begin fails++; $display("FAIL rsv_shadow got %h %h exp %h %h", o_dat, o_ena, ref_dat[2], ref_en[2]); end
    do_write(32'h18, HSIZE_WORD, 32'hFFFF_FFFF);
    tests++; if (write_byte !== 4'h0 || group_id !== 4'd1) begin fails++; $display("FAIL in_write got wb %h gid %h exp 0 1", write_byte, group_id); end
    tests++; if (o_dat !== ref_dat[1] || o_ena !== ref_en[1]) begin fails++; $display("FAIL in_write_shadow got %h %h exp %h %h", o_dat, o_ena, ref_dat[1], ref_en[1]); end
    do_read(32'h2C, HSIZE_WORD, d);
    tests++; if (d !== 32'h0 || rd_waits != 0) begin fails++; $display("FAIL rsv_read got %h waits %0d exp 0 0", d, rd_waits); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    ahb_addr(32'h28, 1'b0, HSIZE_WORD);
    @(posedge clk); #1;
    ahb_idle_addr();
    @(posedge clk); #1;
    tests++; if (bus.HREADYOUT !== 1'b0) begin fails++; $display("FAIL rst_mid_pre_ready got %b exp 0", bus.HREADYOUT); end
    #2 rst = 1'b1;
    #1;
    tests++; if (bus.HREADYOUT !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got %b exp 1", bus.HREADYOUT); end
    tests++; if (o_dat !== 32'h0 || o_ena !== 32'h0 || group_id !== 4'h0) begin fails++; $display("FAIL rst_mid_shadow got %h %h gid %h exp 0", o_dat, o_ena, group_id); end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin ref_dat[i] = '0; ref_en[i] = '0; end
    @(posedge clk); #1;
    do_read(32'h10, HSIZE_WORD, d);
    tests++; if (d !== 32'h0 || rd_waits != 0) begin fails++; $display("FAIL rst_mid_after got %h waits %0d exp 0 0", d, rd_waits); end
  endtask

  task automatic test_random();
    logic [3:0]  wb;
    logic [31:0] d;
    logic [31:0] data;
    logic [31:0] exp;
    logic [5:0]  a;
    logic [2:0]  s;
    logic [1:0]  g;
    logic [1:0]  kind;
    logic [1:0]  low;
    for (int n = 0; n < 60; n++) begin
      g    = 2'($urandom_range(0, 3));
      kind = 2'($urandom_range(0, 3));
      s    = 3'($urandom_range(0, 3));
      low  = 2'($urandom_range(0, 3));
      if (s == HSIZE_HALF) low[0] = 1'b0;
      if (s == HSIZE_WORD) low = 2'b00;
      a    = {g, kind, low};
      data = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        do_write({26'h0, a}, s, data);
        ref_write(a, s, data, wb);
        tests++; if (group_id !== {2'b00, g} || write_byte !== wb) begin fails++; $display("FAIL rnd_write a=%h s=%0d got gid %h wb %b exp %h %b", a, s, group_id, write_byte, g, wb); end
        tests++; if (o_dat !== ref_dat[g] || o_ena !== ref_en[g]) begin fails++; $display("FAIL rnd_shadow g=%0d got %h %h exp %h %h", g, o_dat, o_ena, ref_dat[g], ref_en[g]); end
      end else begin
        if (kind == 2'd2) begin
          ext_en[g]  = '1;
          ext_val[g] = $urandom;
        end
        case (kind)
          2'd0:    exp = ref_dat[g];
          2'd1:    exp = ref_en[g];
          2'd2:    exp = pin_val(ref_en[g], ref_dat[g], ext_en[g], ext_val[g]);
          default: exp = 32'h0;
        endcase
        do_read({26'h0, a}, s, d);
        tests++; if (d !== exp) begin fails++; $display("FAIL rnd_read a=%h got %h exp %h", a, d, exp); end
        tests++; if (rd_waits != ((kind == 2'd2) ? 2 : 0)) begin fails++; $display("FAIL rnd_waits a=%h got %0d exp %0d", a, rd_waits, (kind == 2'd2) ? 2 : 0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_write();
    test_in_read();
    test_back_to_back();
    test_reserved();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ahb_gpio_bridge.md
Name: ahb_gpio_bridge

Overview:
- AHB-Lite slave that sits directly upstream of the 4-group GPIO block and drives its write_byte/group_id/o_ena/o_dat/i_dat interface.
- Holds shadow output-data and output-enable registers for each group.
- Sequences group_id so that every register write reaches the GPIO output register of the correct group.
- Serves input-pin reads with fixed wait states that cover the GPIO's one-cycle input register.

Parameters:
- GROUP_NUM, 4, number of GPIO groups; matches the downstream block and is fixed.
- GROUP_W, 4, width of the group_id port.

Ports:
- clk  input  1  system clock
- RST  input  1  asynchronous reset, active-high
- HSEL  input  1  slave select
- HADDR  input  32  address; only [5:0] decoded
- HTRANS  input  2  transfer type; NONSEQ/SEQ active
- HSIZE  input  3  0=byte, 1=half, 2=word
- HWRITE  input  1  write=1
- HWDATA  input  32  write data (data phase)
- HREADY  input  1  bus ready
- HREADYOUT  output  1  slave ready
- HRDATA  output  32  read data
- HRESP  output  1  tied 0 (OKAY)
- write_byte  output  4  byte lanes of the write just committed; one-cycle pulse
- group_id  output  GROUP_W  group currently addressed at the GPIO
- o_ena  output  32  equals shadow_en[group_id]
- o_dat  output  32  equals shadow_dat[group_id]
- i_dat  input  32  registered pin value of group_id, from the GPIO

Behaviour:
- Reset:
  - Reset is asynchronous, active-high.
  - shadow_dat[*]=0, shadow_en[*]=0, group_id=0, write_byte=0.
  - HREADYOUT=1, HRDATA=0, FSM=IDLE.
  - Because o_ena=0 after reset, all pins stay Z.
- Register map: g=HADDR[5:4], off=HADDR[3:0].
  - 0x0 OUT: RW.
  - 0x4 OEN: RW.
  - 0x8 IN: RO; writes ignored.
  - 0xC: reserved; reads 0, writes ignored.
- Accept: an address phase is accepted when HSEL & HTRANS[1] & HREADY. On acceptance, latch g, off, HWRITE, HSIZE and HADDR[1:0].
- Byte strobes:
  - Byte: 1<<addr[1:0].
  - Half: 4'b0011<<{addr[1],1'b0}.
  - Word: 4'b1111.
  - HSIZE>2 is treated as word.
- Write data phase: zero wait states, HREADYOUT=1.
  - At the closing edge, merge HWDATA into shadow_dat[g] (OUT) or shadow_en[g] (OEN) per strobe.
  - At the same edge, set group_id<=g and write_byte<=strobe.
  - write_byte returns to 0 at the next edge unless another write commits.
  - Writes to IN or the reserved offset still set group_id but leave shadows untouched; write_byte=0 in that case.
- Invariant: o_dat/o_ena are combinational from shadow[group_id]. Re-selecting a group therefore rewrites identical values into the GPIO.
- OUT/OEN/reserved read: zero wait states; HRDATA = shadow or 0, driven in the data phase.
- IN read FSM:
  - IDLE -> RD_SEL on acceptance of an IN read.
  - RD_SEL: HREADYOUT=0, group_id held (lets a write committed at the same edge reach the GPIO); at its end, group_id<=g.
  - RD_WAIT: HREADYOUT=0; the GPIO samples io_pin[g] at its end.
  - RD_DONE: HREADYOUT=1, HRDATA=i_dat; returns to IDLE, or accepts the next address.
  - Net cost: exactly 2 wait states.
- No new address is accepted while HREADYOUT=0, because HREADY is low.
- Back-to-back cases:
  - Write to group a followed by an IN read of group b: group_id=a for at least one edge, then b.
  - Consecutive writes to different groups: each group is held for exactly one edge, which is sufficient.
- HTRANS IDLE/BUSY or HSEL=0: no state change; HREADYOUT=1.
- Reset mid-read: FSM goes to IDLE, HREADYOUT=1, and the pending read is discarded.

Decomposition:
- Package gpio_pkg holds:
  - GROUP_NUM and the offset constants OFF_OUT=4'h0, OFF_OEN=4'h4, OFF_IN=4'h8.
  - An FSM state enum {IDLE, RD_SEL, RD_WAIT, RD_DONE}.
  - The HTRANS and HSIZE encodings.
- One natural sub-module: ahb_byte_strobe, a combinational function from HSIZE and addr[1:0] to strobe[3:0]. Reused for the merge and for write_byte.
- Everything else stays flat.

Test Plan:
- Reset: after RST, o_ena=0, o_dat=0, group_id=0, HREADYOUT=1, and all GPIO pins are Z.
- Word write OEN g1=0x0000_00FF, then OUT g1=0x1234_56A5:
  - group_id=1 and write_byte=4'hF for one cycle after each write.
  - io_pin1[7:0]=0xA5; io_pin1[31:8] stays Z.
- Byte write 0x5A to OUT g2 addr 0x21 (HSIZE=0) over shadow 0xFFFF_FFFF:
  - shadow_dat[2]=0xFFFF_5AFF and write_byte=4'b0010.
  - Readback at 0x20 returns the same value with 0 wait states.
- IN read of g3 with io_pin3 externally driven to 0xCAFE_F00D:
  - HREADYOUT low for exactly 2 cycles; HRDATA=0xCAFE_F00D.
  - group_id reads 3 from RD_WAIT onward.
- Back-to-back write OUT g0=0x1 then IN read g1:
  - group_id sequence 0 then 1.
  - io_pin0[0]=1 after setting OEN g0 bit0; the read completes correctly.
- Assert RST during RD_WAIT: HREADYOUT=1 immediately, FSM=IDLE, shadows=0.
- Reserved 0xC: read returns 0.
